// File: rtl/window_max_tracker.sv
// Purpose : tracks the running maximum (strict greater-than, first occurrence wins)
//           of each window of N accepted samples and presents max + index once per window.
// Latency : m_valid rises on the edge that accepts the Nth sample; no extra pipeline stage.
// Backpressure: s_ready is low while a result is held; result waits for m_ready.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   clear               synchronous window abort, discards partial window or held result
//   s_valid/s_ready     sample handshake, s_data unsigned W-bit sample
//   m_valid/m_ready     result handshake, m_max window maximum, m_index its position
//   busy                window partially filled or result pending
module window_max_tracker #(
  parameter int W  = 4,
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          s_valid,
  input  logic [W-1:0]  s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [W-1:0]  m_max,
  output logic [IW-1:0] m_index,
  input  logic          m_ready,
  output logic          busy
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] count_q, count_d;
  logic [W-1:0]  max_q, max_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  m_max_q, m_max_d;
  logic [IW-1:0] m_index_q, m_index_d;

  logic          accept;
  logic [W-1:0]  new_max;
  logic [IW-1:0] new_idx;

  // clear wins over a sample presented in the same cycle
  assign accept = (state_q == ACCUM) && s_valid && !clear;

  // Candidate max/index if the current sample were accepted. The first sample
  // of a window loads unconditionally so a stale max never leaks across windows.
  always_comb begin
    new_max = max_q;
    new_idx = idx_q;
    if (count_q == '0) begin
      new_max = s_data;
      new_idx = '0;
    end else if (s_data > max_q) begin
      new_max = s_data;
      new_idx = count_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    idx_d     = idx_q;
    m_max_d   = m_max_q;
    m_index_d = m_index_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          count_d   = '0;
          max_d     = '0;
          idx_d     = '0;
          m_max_d   = '0;
          m_index_d = '0;
        end else if (accept) begin
          max_d = new_max;
          idx_d = new_idx;
          if (count_q == LAST) begin
            // result includes the Nth sample's own comparison
            count_d   = '0;
            state_d   = HOLD;
            m_max_d   = new_max;
            m_index_d = new_idx;
          end else begin
            count_d = count_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (clear) begin
          // result is dropped even if m_ready is high this cycle
          state_d   = ACCUM;
          max_d     = '0;
          idx_d     = '0;
          m_max_d   = '0;
          m_index_d = '0;
        end else if (m_ready) begin
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      m_max_q   <= '0;
      m_index_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      m_max_q   <= m_max_d;
      m_index_q <= m_index_d;
    end
  end

  // s_ready comes straight from state, so the handshake cycle never accepts a sample
  assign s_ready = (state_q == ACCUM);
  assign m_valid = (state_q == HOLD);
  assign m_max   = m_max_q;
  assign m_index = m_index_q;
  assign busy    = (state_q == HOLD) || (count_q != '0);

  a_no_x_data : assert property (@(posedge clk) disable iff (!reset_n)
                                 s_valid |-> !$isunknown(s_data))
    else $error("window_max_tracker: s_valid with unknown s_data");

endmodule

// File: doc/window_max_tracker.md
Name: window_max_tracker

Overview:
- Streaming block directly downstream of the gt4 magnitude comparator.
- Accepts a valid/ready stream of unsigned W-bit samples and applies the strict greater-than test to each sample against a running maximum.
- After every N accepted samples, presents the window maximum and its position for one output handshake.
- Feeds display and peak-hold logic in the prototyping designs.

Parameters:
- W, 4, sample width in bits. Comparison is unsigned and strict greater-than, the same as gt4 semantics.
- N, 8, samples per window. Legal range 2..256.
- IW, 3, index width. Must satisfy 2^IW >= N.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous window abort. Active high.
- s_valid  input  1  input sample valid.
- s_data  input  W  input sample, unsigned.
- s_ready  output  1  block can accept a sample.
- m_valid  output  1  window result valid.
- m_max  output  W  maximum sample of the completed window.
- m_index  output  IW  position (0..N-1) of the first occurrence of m_max within the window.
- m_ready  input  1  downstream accepts the result.
- busy  output  1  window partially filled (count > 0) or result pending.

Behaviour:
- Reset is asynchronous and active-low. Asserting reset_n=0 immediately forces:
  - state=ACCUM, count=0, max_r=0, idx_r=0;
  - s_ready=1, m_valid=0, m_max=0, m_index=0, busy=0.
- Deassertion is sampled on clk. The first sample can be accepted on the first rising edge with reset_n=1.
- State ACCUM:
  - s_ready=1, m_valid=0.
  - A sample is accepted on a rising edge where s_valid && s_ready.
  - On accept with count==0: max_r<=s_data and idx_r<=0, unconditionally.
  - On accept with count>0: if s_data > max_r (strict), max_r<=s_data and idx_r<=count. Otherwise hold.
  - Ties keep the earliest index.
  - count increments on every accept.
  - On the accept where count==N-1: count<=0, state<=HOLD, and m_max/m_index are loaded with the final max and index, including the Nth sample's comparison.
- State HOLD:
  - s_ready=0, m_valid=1.
  - m_max and m_index are stable while m_valid=1 && m_ready=0.
  - On m_valid && m_ready: state<=ACCUM and m_valid drops the next cycle.
  - No sample is accepted in the handshake cycle, because s_ready is registered from state. Throughput is therefore N+1 cycles per window at best.
- Latency: m_valid rises on the clock edge that accepts the Nth sample, i.e. it is visible in the cycle after that accept.
- Comparison is purely combinational on s_data vs max_r. It is registered only through max_r/idx_r, with no extra pipeline stage.
- clear:
  - In ACCUM: count<=0, max_r<=0, idx_r<=0. Any sample presented in the same cycle is dropped; clear has priority over accept.
  - In HOLD: discards the pending result, m_valid<=0, state<=ACCUM. This applies even if m_ready=1 in the same cycle; the result is not considered delivered.
- busy = (state==HOLD) || (count!=0).
- count wraps only via the N-1 rule. No other overflow path exists.
- m_max/m_index hold their last delivered values after the handshake. They are not cleared until the next window completes, clear, or reset.
- Reset mid-window or mid-HOLD discards all partial state with no output.
- Behaviour for s_data containing X is undefined. Assertions flag s_valid=1 with X data.

Test Plan (W=4, N=4, IW=2):
- Reset release, then samples 3,9,2,7 back-to-back with m_ready=1 -> m_valid high for 1 cycle after 4th accept, m_max=9, m_index=1; s_ready low for exactly that cycle.
- Tie handling: samples 5,12,12,4 -> m_max=12, m_index=1 (first occurrence). Samples 0,0,0,0 -> m_max=0, m_index=0.
- Backpressure: samples 1,2,3,15 with m_ready=0 for 6 cycles while s_valid=1 with data 8 -> s_ready=0, m_max=15/m_index=3 stable for all 6 cycles, the 8 is not consumed. After m_ready=1, the next window starts with the 8 at index 0.
- Gapped input: samples 6,_,_,14,_,2,11 with s_valid low on gaps -> only valid beats count; result m_max=14, m_index=1.
- clear after 2 samples (10,13), then 4,5,6,1 -> single result m_max=6, m_index=2. clear in HOLD with m_ready=1 -> no handshake counted, busy=0 next cycle.
- Async reset pulse mid-window (after samples 9,3) between clock edges -> outputs zero immediately, no m_valid. Next 4 samples 2,2,8,1 -> m_max=8, m_index=2.
